// File: rtl/croc_pkg.sv
// Shared JTAG host types: operation codes, host FSM states, shift-length width
// and the TAP navigation TMS tables.
package croc_pkg;

    localparam int unsigned LenW = 5;

    typedef enum logic [1:0] {
        OP_RESET    = 2'd0,
        OP_SHIFT_IR = 2'd1,
        OP_SHIFT_DR = 2'd2
    } jtag_op_e;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_NAV   = 3'd1,
        ST_SHIFT = 3'd2,
        ST_EXIT  = 3'd3,
        ST_RESP  = 3'd4
    } host_state_e;

    // TMS for navigation bit idx: reset is 1,1,1,1,1,0; IR prefix 1,1,0,0; DR prefix 1,0,0
    function automatic logic nav_tms(jtag_op_e op, logic [LenW-1:0] idx);
        case (op)
            OP_SHIFT_IR: return (idx < 5'd2);
            OP_SHIFT_DR: return (idx == 5'd0);
            default:     return (idx != 5'd5);
        endcase
    endfunction

    function automatic logic [LenW-1:0] nav_last(jtag_op_e op);
        case (op)
            OP_SHIFT_IR: return 5'd3;
            OP_SHIFT_DR: return 5'd2;
            default:     return 5'd5;
        endcase
    endfunction

endpackage

// File: rtl/jtag_host_tck_gen.sv
// TCK divider: toggles TCK every ClkDiv enabled cycles and flags the cycle
// on which TCK is about to rise or fall.
module jtag_host_tck_gen #(
    parameter int unsigned ClkDiv = 4
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic en_i,
    output logic tck_o,
    output logic rise_o,
    output logic fall_o
);

    localparam logic [7:0] CntMax = 8'(ClkDiv - 1);

    logic [7:0] cnt_q, cnt_d;
    logic       tck_q, tck_d;
    logic       wrap_s;

    assign wrap_s = en_i && (cnt_q == CntMax);
    assign rise_o = wrap_s && !tck_q;
    assign fall_o = wrap_s && tck_q;
    assign tck_o  = tck_q;

    always_comb begin
        cnt_d = cnt_q;
        tck_d = tck_q;
        if (!en_i) begin
            cnt_d = 8'd0;
            tck_d = 1'b0;
        end else if (wrap_s) begin
            cnt_d = 8'd0;
            tck_d = ~tck_q;
        end else begin
            cnt_d = cnt_q + 8'd1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            cnt_q <= 8'd0;
            tck_q <= 1'b0;
        end else begin
            cnt_q <= cnt_d;
            tck_q <= tck_d;
        end
    end

endmodule

// File: rtl/jtag_host.sv
// JTAG host: accepts reset / IR-shift / DR-shift commands, walks the target TAP
// from Run-Test/Idle through the shift and back, and returns the captured TDO.
module jtag_host
    import croc_pkg::*;
#(
    parameter int unsigned ClkDiv = 4,
    parameter int unsigned MaxLen = 32
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              cmd_valid_i,
    output logic              cmd_ready_o,
    input  logic [1:0]        cmd_op_i,
    input  logic [LenW-1:0]   cmd_len_i,
    input  logic [MaxLen-1:0] cmd_data_i,
    output logic              rsp_valid_o,
    input  logic              rsp_ready_i,
    output logic [MaxLen-1:0] rsp_data_o,
    output logic              jtag_tck_o,
    output logic              jtag_tms_o,
    output logic              jtag_tdi_o,
    input  logic              jtag_tdo_i,
    output logic              jtag_trst_no
);

    host_state_e       state_q, state_d;
    jtag_op_e          op_q, op_d;
    logic [LenW-1:0]   len_q, len_d;
    logic [LenW-1:0]   bit_q, bit_d;
    logic [LenW-1:0]   bit_nxt_s;
    logic [MaxLen-1:0] data_q, data_d;
    logic [MaxLen-1:0] rsp_q, rsp_d;
    logic              tms_q, tms_d;
    logic              tdi_q, tdi_d;
    logic              ready_q, valid_q, trst_q;
    logic              tck_en_s, rise_s, fall_s;

    assign tck_en_s  = (state_q == ST_NAV) || (state_q == ST_SHIFT) || (state_q == ST_EXIT);
    assign bit_nxt_s = bit_q + 5'd1;

    jtag_host_tck_gen #(.ClkDiv(ClkDiv)) u_tck_gen (
        .clk_i  (clk_i),
        .rst_i  (rst_i),
        .en_i   (tck_en_s),
        .tck_o  (jtag_tck_o),
        .rise_o (rise_s),
        .fall_o (fall_s)
    );

    // TMS/TDI for the next bit are set on the falling-edge strobe, so each phase hands over seamlessly
    always_comb begin
        state_d = state_q;
        op_d    = op_q;
        len_d   = len_q;
        data_d  = data_q;
        bit_d   = bit_q;
        tms_d   = tms_q;
        tdi_d   = tdi_q;
        rsp_d   = rsp_q;
        case (state_q)
            ST_IDLE: begin
                if (cmd_valid_i && ready_q) begin
                    op_d    = ((cmd_op_i == 2'd1) || (cmd_op_i == 2'd2)) ? jtag_op_e'(cmd_op_i) : OP_RESET;
                    len_d   = cmd_len_i;
                    data_d  = cmd_data_i;
                    rsp_d   = '0;
                    bit_d   = 5'd0;
                    tms_d   = 1'b1;
                    tdi_d   = 1'b0;
                    state_d = ST_NAV;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_NAV: begin
                if (fall_s && (bit_q == nav_last(op_q))) begin
                    bit_d   = 5'd0;
                    state_d = (op_q == OP_RESET) ? ST_RESP : ST_SHIFT;
                    tms_d   = (op_q == OP_RESET) ? tms_q : (len_q == 5'd0);
                    tdi_d   = (op_q == OP_RESET) ? 1'b0 : data_q[0];
                end else if (fall_s) begin
                    bit_d = bit_nxt_s;
                    tms_d = nav_tms(op_q, bit_nxt_s);
                end else begin
                    state_d = ST_NAV;
                end
            end
            ST_SHIFT: begin
                if (rise_s) begin
                    rsp_d[bit_q] = jtag_tdo_i;
                end else if (fall_s && (bit_q == len_q)) begin
                    bit_d   = 5'd0;
                    tms_d   = 1'b1;
                    tdi_d   = 1'b0;
                    state_d = ST_EXIT;
                end else if (fall_s) begin
                    bit_d = bit_nxt_s;
                    tms_d = (bit_nxt_s == len_q);
                    tdi_d = data_q[bit_nxt_s];
                end else begin
                    state_d = ST_SHIFT;
                end
            end
            ST_EXIT: begin
                if (fall_s && (bit_q == 5'd1)) begin
                    bit_d   = 5'd0;
                    state_d = ST_RESP;
                end else if (fall_s) begin
                    bit_d = 5'd1;
                    tms_d = 1'b0;
                end else begin
                    state_d = ST_EXIT;
                end
            end
            ST_RESP: begin
                if (rsp_ready_i) begin
                    state_d = ST_IDLE;
                end else begin
                    state_d = ST_RESP;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= ST_IDLE;
            op_q    <= OP_RESET;
            len_q   <= 5'd0;
            bit_q   <= 5'd0;
            data_q  <= '0;
            rsp_q   <= '0;
            tms_q   <= 1'b1;
            tdi_q   <= 1'b0;
            ready_q <= 1'b0;
            valid_q <= 1'b0;
            trst_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            op_q    <= op_d;
            len_q   <= len_d;
            bit_q   <= bit_d;
            data_q  <= data_d;
            rsp_q   <= rsp_d;
            tms_q   <= tms_d;
            tdi_q   <= tdi_d;
            ready_q <= (state_d == ST_IDLE);
            valid_q <= (state_d == ST_RESP);
            trst_q  <= 1'b1;
        end
    end

    assign cmd_ready_o  = ready_q;
    assign rsp_valid_o  = valid_q;
    assign rsp_data_o   = rsp_q;
    assign jtag_tms_o   = tms_q;
    assign jtag_tdi_o   = tdi_q;
    assign jtag_trst_no = trst_q;

endmodule

// File: tb/tb_jtag_host.sv
// Randomized bench for jtag_host against a behavioural IEEE 1149.1 TAP target
// holding IDCODE 0x1C0FFEE1 and a 5-bit IR that captures 5'b00001.
module tb_jtag_host;

    localparam int unsigned ClkDiv = 2;
    localparam int unsigned MaxLen = 32;
    localparam logic [31:0] IdCode = 32'h1C0FFEE1;

    typedef enum logic [3:0] {
        TLR, RTI, SELDR, CAPDR, SHDR, EX1DR, PADR, EX2DR, UPDR,
        SELIR, CAPIR, SHIR, EX1IR, PAIR, EX2IR, UPIR
    } tap_e;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        cmd_valid = 1'b0;
    logic        cmd_ready;
    logic [1:0]  cmd_op = 2'd0;
    logic [4:0]  cmd_len = 5'd0;
    logic [31:0] cmd_data = 32'd0;
    logic        rsp_valid;
    logic        rsp_ready = 1'b0;
    logic [31:0] rsp_data;
    logic        tck, tms, tdi, trst_n;
    logic        tdo = 1'b0;

    int checks = 0;
    int failures = 0;
    int unsigned cyc = 0;

    tap_e        tap_st = TLR;
    logic [31:0] tap_dr = 32'd0;
    logic [4:0]  tap_ir = 5'd0;
    bit          tms_log[$];
    bit          tdi_log[$];
    int unsigned rise_q[$];
    int unsigned fall_q[$];

    jtag_host #(.ClkDiv(ClkDiv), .MaxLen(MaxLen)) dut (
        .clk_i(clk), .rst_i(rst),
        .cmd_valid_i(cmd_valid), .cmd_ready_o(cmd_ready),
        .cmd_op_i(cmd_op), .cmd_len_i(cmd_len), .cmd_data_i(cmd_data),
        .rsp_valid_o(rsp_valid), .rsp_ready_i(rsp_ready), .rsp_data_o(rsp_data),
        .jtag_tck_o(tck), .jtag_tms_o(tms), .jtag_tdi_o(tdi),
        .jtag_tdo_i(tdo), .jtag_trst_no(trst_n)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic tap_e tap_next(tap_e s, logic m);
        case (s)
            TLR:   return m ? TLR   : RTI;
            RTI:   return m ? SELDR : RTI;
            SELDR: return m ? SELIR : CAPDR;
            CAPDR: return m ? EX1DR : SHDR;
            SHDR:  return m ? EX1DR : SHDR;
            EX1DR: return m ? UPDR  : PADR;
            PADR:  return m ? EX2DR : PADR;
            EX2DR: return m ? UPDR  : SHDR;
            UPDR:  return m ? SELDR : RTI;
            SELIR: return m ? TLR   : CAPIR;
            CAPIR: return m ? EX1IR : SHIR;
            SHIR:  return m ? EX1IR : SHIR;
            EX1IR: return m ? UPIR  : PAIR;
            PAIR:  return m ? EX2IR : PAIR;
            EX2IR: return m ? UPIR  : SHIR;
            UPIR:  return m ? SELDR : RTI;
            default: return TLR;
        endcase
    endfunction

    // Target TAP: samples TMS/TDI on rising TCK
    always @(posedge tck or negedge trst_n) begin
        if (!trst_n) begin
            tap_st <= TLR;
        end else begin
            tms_log.push_back(tms);
            rise_q.push_back(cyc);
            if (tap_st == CAPDR) tap_dr <= IdCode;
            if (tap_st == CAPIR) tap_ir <= 5'b00001;
            if (tap_st == SHDR) begin
                tap_dr <= {tdi, tap_dr[31:1]};
                tdi_log.push_back(tdi);
            end
            if (tap_st == SHIR) begin
                tap_ir <= {tdi, tap_ir[4:1]};
                tdi_log.push_back(tdi);
            end
            tap_st <= tap_next(tap_st, tms);
        end
    end

    // Target drives TDO on falling TCK
    always @(negedge tck) begin
        fall_q.push_back(cyc);
        tdo <= (tap_st == SHDR) ? tap_dr[0] : (tap_st == SHIR) ? tap_ir[0] : 1'b0;
    end

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        check_eq({tag, "_tck"}, 64'(tck), 64'd0);
        check_eq({tag, "_tms"}, 64'(tms), 64'd1);
        check_eq({tag, "_tdi"}, 64'(tdi), 64'd0);
        check_eq({tag, "_trst_n"}, 64'(trst_n), 64'd0);
        check_eq({tag, "_cmd_ready"}, 64'(cmd_ready), 64'd0);
        check_eq({tag, "_rsp_valid"}, 64'(rsp_valid), 64'd0);
        check_eq({tag, "_rsp_data"}, 64'(rsp_data), 64'd0);
    endtask

    task automatic issue_cmd(input int op, input int len, input logic [31:0] data);
        int w;
        tms_log.delete(); tdi_log.delete(); rise_q.delete(); fall_q.delete();
        @(negedge clk);
        cmd_valid = 1'b1; cmd_op = 2'(op); cmd_len = 5'(len); cmd_data = data;
        w = 0;
        while (!cmd_ready && w < 100) begin @(negedge clk); w++; end
        check_eq("cmd_accept", 64'(cmd_ready), 64'd1);
        @(negedge clk);
        cmd_valid = 1'b0;
    endtask

    task automatic run_cmd(input int op, input int len, input logic [31:0] data, input int hold);
        int w, n_tms, n_tdi, bad, width, rises;
        logic [63:0] exp_tms, got_tms, exp_tdi, got_tdi;
        logic [31:0] exp_rsp, cap;
        bit is_shift;
        issue_cmd(op, len, data);
        w = 0;
        while (!rsp_valid && w < 2000) begin @(negedge clk); w++; end
        check_eq("rsp_valid", 64'(rsp_valid), 64'd1);

        // Expected sequences straight from the TAP walk rules
        is_shift = (op == 1) || (op == 2);
        exp_tms = '0; n_tms = 0; exp_rsp = '0; exp_tdi = '0; n_tdi = 0;
        if (!is_shift) begin
            exp_tms = 64'b011111; n_tms = 6;
        end else begin
            exp_tms[n_tms++] = 1'b1;
            if (op == 1) exp_tms[n_tms++] = 1'b1;
            exp_tms[n_tms++] = 1'b0;
            exp_tms[n_tms++] = 1'b0;
            for (int k = 0; k <= len; k++) exp_tms[n_tms++] = (k == len);
            exp_tms[n_tms++] = 1'b1;
            exp_tms[n_tms++] = 1'b0;
            width = (op == 2) ? 32 : 5;
            cap   = (op == 2) ? IdCode : 32'd1;
            for (int k = 0; k <= len; k++) begin
                exp_rsp[k] = (k < width) ? cap[k] : data[k - width];
                exp_tdi[k] = data[k];
            end
            n_tdi = len + 1;
        end
        got_tms = '0;
        foreach (tms_log[i]) if (i < 64) got_tms[i] = tms_log[i];
        got_tdi = '0;
        foreach (tdi_log[i]) if (i < 64) got_tdi[i] = tdi_log[i];

        check_eq("rsp_data", 64'(rsp_data), 64'(exp_rsp));
        check_eq("tms_count", 64'(tms_log.size()), 64'(n_tms));
        check_eq("tms_seq", got_tms, exp_tms);
        check_eq("tdi_count", 64'(tdi_log.size()), 64'(n_tdi));
        check_eq("tdi_seq", got_tdi, exp_tdi);
        check_eq("tap_in_rti", 64'(tap_st), 64'(RTI));

        bad = (rise_q.size() == fall_q.size()) ? 0 : 1;
        for (int i = 0; i < rise_q.size() && i < fall_q.size(); i++) begin
            if (fall_q[i] - rise_q[i] != ClkDiv) bad++;
            if (i > 0 && rise_q[i] - rise_q[i-1] != 2 * ClkDiv) bad++;
        end
        check_eq("tck_timing", 64'(bad), 64'd0);

        for (int i = 0; i < hold; i++) begin
            cmd_valid = 1'b1; cmd_op = 2'd2; cmd_len = 5'd7; cmd_data = $urandom;
            check_eq("bp_valid", 64'(rsp_valid), 64'd1);
            check_eq("bp_data", 64'(rsp_data), 64'(exp_rsp));
            check_eq("bp_cmd_ready", 64'(cmd_ready), 64'd0);
            @(negedge clk);
        end
        cmd_valid = 1'b0;
        rsp_ready = 1'b1;
        @(negedge clk);
        rsp_ready = 1'b0;
        check_eq("rsp_released", 64'(rsp_valid), 64'd0);
        check_eq("ready_again", 64'(cmd_ready), 64'd1);
        if (hold > 0) begin
            rises = rise_q.size();
            repeat (10) @(negedge clk);
            check_eq("bp_cmd_dropped", 64'(rise_q.size()), 64'(rises));
        end
    endtask

    initial begin
        int w, op;
        bit seen_valid;

        repeat (3) @(negedge clk);
        check_reset_outputs("rst");
        rst = 1'b0;
        @(negedge clk);
        check_eq("rel_cmd_ready", 64'(cmd_ready), 64'd1);
        check_eq("rel_trst_n", 64'(trst_n), 64'd1);

        run_cmd(0, 0, 32'd0, 0);
        run_cmd(2, 31, 32'hDEADBEEF, 0);
        run_cmd(1, 4, 32'h00000001, 20);

        // Reset during shift bit 10 of a DR shift
        issue_cmd(2, 31, $urandom);
        w = 0;
        while (tdi_log.size() < 10 && w < 1000) begin @(negedge clk); w++; end
        check_eq("reach_bit10", 64'(tdi_log.size()), 64'd10);
        rst = 1'b1;
        @(negedge clk);
        check_reset_outputs("abort");
        @(negedge clk);
        rst = 1'b0;
        seen_valid = 1'b0;
        repeat (300) begin
            @(negedge clk);
            if (rsp_valid) seen_valid = 1'b1;
        end
        check_eq("abort_no_rsp", 64'(seen_valid), 64'd0);
        check_eq("abort_ready", 64'(cmd_ready), 64'd1);

        run_cmd(0, 0, 32'd0, 0);
        for (int t = 0; t < 16; t++) begin
            op = $urandom_range(0, 3);
            run_cmd(op, $urandom_range(0, 31), $urandom, $urandom_range(0, 3));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
